// File: rtl/bk_pkg.sv
// Shared types and the G/P black-cell operator for the Brent-Kung prefix pipe.
package bk_pkg;

  localparam int BK_WIDTH  = 32;
  localparam int BK_LEVELS = $clog2(BK_WIDTH);

  typedef struct packed {
    logic g;
    logic p;
  } pg_t;

  // (G,P)hi o (G,P)lo: hi span absorbs the lower span below it.
  function automatic pg_t bk_combine(input pg_t hi, input pg_t lo);
    pg_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

endpackage

// File: rtl/bk_black_cell.sv
// One 2-input group generate/propagate combine.
module bk_black_cell
  import bk_pkg::*;
(
  input  pg_t hi_i,
  input  pg_t lo_i,
  output pg_t pg_o
);

  assign pg_o = bk_combine(hi_i, lo_i);

endmodule

// File: rtl/bk_prefix_sum_pipe.sv
// Two-stage Brent-Kung prefix network + sum, valid/ready with pass-through ready.
// Stage 1: carry fold + up-sweep, registered. Stage 2: down-sweep + sum, registered.
module bk_prefix_sum_pipe
  import bk_pkg::*;
#(
  parameter int WIDTH = BK_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_p,
  input  logic [WIDTH-1:0] in_g,
  input  logic             in_c0,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int LV = $clog2(WIDTH);

  // ---------------- handshake ----------------
  logic s1_valid_q, s1_valid_d;
  logic out_valid_q, out_valid_d;
  logic s2_ready, s1_ready, in_fire, s1_fire;

  assign s2_ready = !out_valid_q || out_ready;
  assign s1_ready = !s1_valid_q || s2_ready;
  assign in_ready = s1_ready;
  assign in_fire  = in_valid && s1_ready;
  assign s1_fire  = s1_valid_q && s2_ready;

  // A stage refills (or empties) only when its downstream can take its content.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    out_valid_d = out_valid_q;
    if (s1_ready) s1_valid_d  = in_valid;
    if (s2_ready) out_valid_d = s1_valid_q;
  end

  // ---------------- stage 1: fold + up-sweep ----------------
  // Level 0 folds c0 into bit 0 so the tree spans exactly WIDTH bits.
  for (genvar l = 0; l <= LV; l++) begin : up
    logic [WIDTH-1:0] g, p;
    if (l == 0) begin : fold
      assign g = {in_g[WIDTH-1:1], in_g[0] | (in_p[0] & in_c0)};
      assign p = in_p;
    end else begin : sweep
      for (genvar i = 0; i < WIDTH; i++) begin : node
        if (((i + 1) % (1 << l)) == 0) begin : blk
          pg_t hi, lo, o;
          assign hi = '{g: up[l-1].g[i], p: up[l-1].p[i]};
          assign lo = '{g: up[l-1].g[i-(1<<(l-1))], p: up[l-1].p[i-(1<<(l-1))]};
          bk_black_cell u_cell (.hi_i(hi), .lo_i(lo), .pg_o(o));
          assign g[i] = o.g;
          assign p[i] = o.p;
        end else begin : pass
          assign g[i] = up[l-1].g[i];
          assign p[i] = up[l-1].p[i];
        end
      end
    end
  end

  logic [WIDTH-1:0] s1_g_q, s1_pp_q, s1_p_q;
  logic             s1_c0_q;

  // Stage 1 register: loads only on an accepted input beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_g_q     <= '0;
      s1_pp_q    <= '0;
      s1_p_q     <= '0;
      s1_c0_q    <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (in_fire) begin
        s1_g_q  <= up[LV].g;
        s1_pp_q <= up[LV].p;
        s1_p_q  <= in_p;
        s1_c0_q <= in_c0;
      end
    end
  end

  // ---------------- stage 2: down-sweep + sum ----------------
  // dn[LV-1] is the registered up-sweep; each lower level fills the odd
  // multiples of its stride. A hi node's up-sweep P is still its own span,
  // so only G travels down and the cell P output is dropped.
  for (genvar l = 0; l < LV; l++) begin : dn
    logic [WIDTH-1:0] g;
    if (l == LV - 1) begin : top
      assign g = s1_g_q;
    end else begin : sweep
      for (genvar i = 0; i < WIDTH; i++) begin : node
        if ((i >= (1 << (l + 1))) && (((i + 1) % (1 << (l + 1))) == (1 << l))) begin : blk
          pg_t hi, lo, o;
          logic unused_p;
          assign hi = '{g: dn[l+1].g[i], p: s1_pp_q[i]};
          assign lo = '{g: dn[l+1].g[i-(1<<l)], p: 1'b0};
          bk_black_cell u_cell (.hi_i(hi), .lo_i(lo), .pg_o(o));
          assign g[i]     = o.g;
          assign unused_p = o.p;
        end else begin : pass
          assign g[i] = dn[l+1].g[i];
        end
      end
    end
  end

  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d, ovf_d;
  logic             unused_pp;

  assign carry     = dn[0].g;
  assign sum_d     = s1_p_q ^ {carry[WIDTH-2:0], s1_c0_q};
  assign cout_d    = carry[WIDTH-1];
  assign ovf_d     = carry[WIDTH-1] ^ carry[WIDTH-2];
  assign unused_pp = ^s1_pp_q;

  logic [WIDTH-1:0] out_sum_q;
  logic             out_cout_q, out_ovf_q;

  // Output register: loads only on an s1->s2 move, holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_cout_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      if (s1_fire) begin
        out_sum_q  <= sum_d;
        out_cout_q <= cout_d;
        out_ovf_q  <= ovf_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_cout  = out_cout_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_bk_prefix_sum_pipe.sv
// Bench for bk_prefix_sum_pipe: directed corners, stall/flush, random streaming
// against an arithmetic A+B+c0 reference queue.
module tb_bk_prefix_sum_pipe;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_p = '0, in_g = '0;
  logic         in_c0 = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_sum;
  logic         out_cout, out_ovf;

  bk_prefix_sum_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_p(in_p), .in_g(in_g), .in_c0(in_c0),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  res_t         q[$];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] a_v = '0, b_v = '0;
  logic         c_v = 1'b0;
  logic         acc, drn;

  function automatic res_t ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    res_t r;
    logic [W:0] t;
    t = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    r.sum  = t[W-1:0];
    r.cout = t[W];
    r.ovf  = (a[W-1] == b[W-1]) && (r.sum[W-1] != a[W-1]);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    a_v = a; b_v = b; c_v = c;
    in_p = a ^ b; in_g = a & b; in_c0 = c;
  endtask

  function automatic logic [W-1:0] rnd_op();
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0:       v = '0;
      1:       v = '1;
      2:       v = 32'h7FFF_FFFF;
      3:       v = 32'h8000_0000;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // One clock: sample handshake at negedge, update scoreboard, return #1 after posedge.
  task automatic cyc();
    res_t e;
    @(negedge clk);
    acc = in_valid && in_ready;
    drn = out_valid && out_ready;
    if (rst) q.delete();
    else begin
      if (drn) begin
        if (q.size() == 0) chk("unexpected_out", {63'd0, out_valid}, 64'd0);
        else begin
          e = q.pop_front();
          chk("sb_sum", {32'd0, out_sum}, {32'd0, e.sum});
          chk("sb_cout", {63'd0, out_cout}, {63'd0, e.cout});
          chk("sb_ovf", {63'd0, out_ovf}, {63'd0, e.ovf});
        end
      end
      if (acc) q.push_back(ref_add(a_v, b_v, c_v));
    end
    @(posedge clk);
    #1;
  endtask

  // Single beat into an empty pipe; result must appear after the second edge.
  task automatic directed(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input logic [W-1:0] esum, input logic ecout,
                          input logic eovf);
    drive(a, b, c);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    cyc();
    in_valid = 1'b0;
    chk({tag, "_valid_lat1"}, {63'd0, out_valid}, 64'd0);
    cyc();
    chk({tag, "_valid_lat2"}, {63'd0, out_valid}, 64'd1);
    chk({tag, "_sum"}, {32'd0, out_sum}, {32'd0, esum});
    chk({tag, "_cout"}, {63'd0, out_cout}, {63'd0, ecout});
    chk({tag, "_ovf"}, {63'd0, out_ovf}, {63'd0, eovf});
  endtask

  initial begin
    int n_acc, ncyc;

    // reset state
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_sum", {32'd0, out_sum}, 64'd0);
    chk("rst_out_cout", {63'd0, out_cout}, 64'd0);
    chk("rst_out_ovf", {63'd0, out_ovf}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

    // directed corners
    directed("wrap",    32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    directed("posovf",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    directed("negovf",  32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
    directed("cin",     32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0, 1'b0);
    directed("ripple",  32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
    cyc();

    // stall: fill both stages, then pass-through ready
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive($urandom, $urandom, 1'($urandom_range(0, 1)));
    cyc();
    chk("st_acc1", {63'd0, acc}, 64'd1);
    drive($urandom, $urandom, 1'($urandom_range(0, 1)));
    cyc();
    chk("st_acc2", {63'd0, acc}, 64'd1);
    drive($urandom, $urandom, 1'($urandom_range(0, 1)));
    chk("st_full_in_ready", {63'd0, in_ready}, 64'd0);
    cyc();
    chk("st_acc3", {63'd0, acc}, 64'd0);
    chk("st_hold_valid", {63'd0, out_valid}, 64'd1);
    chk("st_hold_sum", {32'd0, out_sum}, {32'd0, q[0].sum});
    out_ready = 1'b1;
    #1;
    chk("st_passthru_ready", {63'd0, in_ready}, 64'd1);
    cyc();
    drive($urandom, $urandom, 1'($urandom_range(0, 1)));
    cyc();
    in_valid = 1'b0;
    ncyc = 0;
    while (q.size() != 0 && ncyc < 10) begin cyc(); ncyc++; end
    chk("st_drained", 64'(q.size()), 64'd0);

    // reset with both stages full: flushed beats never come out
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive($urandom, $urandom, 1'b0);
    cyc();
    drive($urandom, $urandom, 1'b1);
    cyc();
    in_valid = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rf_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rf_in_ready", {63'd0, in_ready}, 64'd1);
    out_ready = 1'b1;
    repeat (4) cyc();
    chk("rf_quiet", {63'd0, out_valid}, 64'd0);
    directed("rf_new", 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0);
    cyc();

    // random streaming with random backpressure
    n_acc = 0;
    ncyc  = 0;
    while (n_acc < 10000 && ncyc < 40000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      drive(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)));
      cyc();
      if (acc) n_acc++;
      ncyc++;
    end
    chk("rnd_accepted", 64'(n_acc), 64'd10000);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    ncyc = 0;
    while (q.size() != 0 && ncyc < 20) begin cyc(); ncyc++; end
    chk("rnd_drained", 64'(q.size()), 64'd0);
    chk("rnd_idle_valid", {63'd0, out_valid}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
